// File: rtl/dparm_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dparm_fifo_ctrl
// Description : Synchronous FIFO controller for the dparm dual-port RAM.
//               Converts push/pop requests into RAM write/read port signals,
//               returns RAM read data with a valid strobe, and tracks
//               occupancy with full / empty / almost-full status.
// Revision    : 1.0 - initial release
// ============================================================================
module dparm_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int AFULL_LVL = 240
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   usedw_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              ram_wren_o,
  output logic [ADDR_W-1:0] ram_wraddress_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic [ADDR_W-1:0] ram_rdaddress_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_THR = (ADDR_W+1)'(AFULL_LVL);

  // Pointers carry an extra wrap bit above the RAM address bits.
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] usedw_q,  usedw_d;
  logic            full_q,   full_d;
  logic            empty_q,  empty_d;
  logic            afull_q,  afull_d;
  logic            rd_valid_q;
  logic            overflow_q;
  logic            underflow_q;

  // Acceptance uses only the status registered at the start of the cycle, so
  // a same-cycle pop never frees room for a push and a same-cycle push never
  // feeds a pop. This keeps the RAM from seeing a read and write to one address.
  logic push_ok;
  logic pop_ok;
  assign push_ok = wr_en_i & ~full_q;
  assign pop_ok  = rd_en_i & ~empty_q;

  // Next-state for pointers, occupancy and the status flags derived from it.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
    if (push_ok && !pop_ok)      usedw_d = usedw_q + ONE;
    else if (pop_ok && !push_ok) usedw_d = usedw_q - ONE;
    full_d  = (usedw_d == DEPTH);
    empty_d = (usedw_d == '0);
    afull_d = (usedw_d >= AFULL_THR);
  end

  // State registers; reset discards queued contents and any in-flight read.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      // The RAM registers rdaddress, so data for an accepted pop is on q
      // one clock later; the strobe is delayed to match.
      rd_valid_q  <= pop_ok;
      overflow_q  <= wr_en_i & full_q;
      underflow_q <= rd_en_i & empty_q;
    end
  end

  // RAM port drive; the write strobe is suppressed while reset is held.
  assign ram_wren_o      = push_ok & ~reset_i;
  assign ram_wraddress_o = wr_ptr_q[ADDR_W-1:0];
  assign ram_data_o      = wr_data_i;
  assign ram_rdaddress_o = rd_ptr_q[ADDR_W-1:0];

  assign rd_data_o     = ram_q_i;
  assign rd_valid_o    = rd_valid_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign almost_full_o = afull_q;
  assign usedw_o       = usedw_q;
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dparm_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dparm_fifo_ctrl
// Description : Scoreboard bench for dparm_fifo_ctrl with a behavioural dparm
//               RAM model. Accepted pops queue their expected word; a monitor
//               compares whenever rd_valid is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dparm_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, overflow, underflow;
  logic [8:0] usedw;
  logic       ram_wren;
  logic [7:0] ram_wraddress, ram_data, ram_rdaddress;
  logic [7:0] ram_q;

  dparm_fifo_ctrl #(.DATA_W(8), .ADDR_W(8), .AFULL_LVL(240)) dut (
    .clock_i(clock), .reset_i(reset), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .full_o(full), .empty_o(empty), .almost_full_o(almost_full),
    .usedw_o(usedw), .overflow_o(overflow), .underflow_o(underflow),
    .ram_wren_o(ram_wren), .ram_wraddress_o(ram_wraddress),
    .ram_data_o(ram_data), .ram_rdaddress_o(ram_rdaddress), .ram_q_i(ram_q)
  );

  always #5 clock = ~clock;

  // dparm model: synchronous write, registered read address.
  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  int n_vec = 0;
  int n_err = 0;
  int wren_cnt = 0;
  logic [7:0] exp_q[$];   // scoreboard: words the DUT owes on rd_data
  logic [7:0] m_data[$];  // model FIFO contents
  int m_used = 0;
  int m_wp = 0;
  int m_rp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes one expected word per presented rd_valid.
  always @(negedge clock) begin
    if (!reset) begin
      if (ram_wren) wren_cnt++;
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_valid_unexpected", 1, 0);
        else check("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_status(input logic ovf, input logic unf, input logic rv);
    check("usedw", {23'd0, usedw}, m_used);
    check("full", full, m_used == 256);
    check("empty", empty, m_used == 0);
    check("almost_full", almost_full, m_used >= 240);
    check("overflow", overflow, ovf);
    check("underflow", underflow, unf);
    check("rd_valid", rd_valid, rv);
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic p_ok, q_ok, ovf, unf;
    wr_en = w; wr_data = d; rd_en = r;
    #1;
    p_ok = w && (m_used != 256);
    q_ok = r && (m_used != 0);
    ovf  = w && (m_used == 256);
    unf  = r && (m_used == 0);
    check("ram_wren", ram_wren, p_ok);
    if (p_ok) begin
      check("ram_wraddress", ram_wraddress, m_wp % 256);
      check("ram_data", ram_data, d);
    end
    check("ram_rdaddress", ram_rdaddress, m_rp % 256);
    @(posedge clock);
    if (q_ok) begin
      exp_q.push_back(m_data.pop_front());
      m_rp = (m_rp + 1) % 512;
    end
    if (p_ok) begin
      m_data.push_back(d);
      m_wp = (m_wp + 1) % 512;
    end
    if (p_ok && !q_ok) m_used++;
    if (q_ok && !p_ok) m_used--;
    #1;
    check_status(ovf, unf, q_ok);
  endtask

  // Reset: state must clear immediately, and no RAM write while held.
  task automatic do_reset();
    rd_en = 1'b0;
    wr_en = 1'b1;
    reset = 1'b1;
    #1;
    m_data.delete(); exp_q.delete();
    m_used = 0; m_wp = 0; m_rp = 0;
    check_status(1'b0, 1'b0, 1'b0);
    check("ram_wren_in_reset", ram_wren, 0);
    @(posedge clock);
    #1;
    check("ram_wren_in_reset2", ram_wren, 0);
    check_status(1'b0, 1'b0, 1'b0);
    wr_en = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clock);
    #1;
    do_reset();

    // 1: sixteen back-to-back pushes 0xFF..0xF0
    wren_cnt = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hFF - i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("t1_wren_cycles", wren_cnt, 16);
    check("t1_usedw", {23'd0, usedw}, 16);
    check("t1_empty", empty, 0);

    // 2: sixteen pops return the words in order
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("t2_empty", empty, 1);
    check("t2_usedw", {23'd0, usedw}, 0);
    check("t2_drained", exp_q.size(), 0);

    // 3: fill to 256, then one rejected push
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 238) check("t3_afull_239", almost_full, 0);
      if (i == 239) check("t3_afull_240", almost_full, 1);
    end
    check("t3_full", full, 1);
    step(1'b1, 8'hEE, 1'b0);
    check("t3_overflow", overflow, 1);
    check("t3_usedw", {23'd0, usedw}, 256);
    step(1'b0, 8'h00, 1'b0);
    check("t3_overflow_pulse", overflow, 0);

    // 4: push+pop while full: pop wins, push rejected
    step(1'b1, 8'h55, 1'b1);
    check("t4_overflow", overflow, 1);
    check("t4_usedw", {23'd0, usedw}, 255);
    check("t4_full", full, 0);
    step(1'b0, 8'h00, 1'b0);

    // 5: move pointers to 250, prime 4 words, stream 20 across the wrap
    do_reset();
    for (int i = 0; i < 250; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 250; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'hB0 + i), 1'b1);
      check("t5_usedw_const", {23'd0, usedw}, 4);
    end
    check("t5_wrapped_wraddr", ram_wraddress, 8'd18);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("t5_drained", exp_q.size(), 0);

    // 6: reset mid-stream with 5 words queued and a read in flight
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    check("t6_underflow", underflow, 1);
    step(1'b0, 8'h00, 1'b0);
    check("t6_underflow_pulse", underflow, 0);

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
